// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code fields, emulator state encoding and idle column level.
// The keypad scanner decodes the same row/col fields.
package keypad_pkg;

    localparam int ROW_HI    = 3;
    localparam int ROW_LO    = 2;
    localparam int COL_HI    = 1;
    localparam int COL_LO    = 0;
    localparam int NOKEY_BIT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BNC_P = 3'd1,
        HOLD  = 3'd2,
        BNC_R = 3'd3,
        GAP   = 3'd4
    } estado_t;

    localparam logic [3:0] COLUMNA_IDLE = 4'b1111;

    // Terminal count of a phase of n cycles; a length of 0 behaves as 1.
    function automatic int fin_fase(input int n);
        return (n < 1) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/keypad_emulador_if.sv
// Key-code handshake between a test sequencer (master) and the keypad emulator (slave).
interface keypad_emulador_if;
    logic [4:0] key_in;
    logic       key_valid;
    logic       key_ready;
    logic       busy;

    modport master (output key_in, key_valid, input key_ready, busy);
    modport slave  (input key_in, key_valid, output key_ready, busy);
endinterface

// File: rtl/keypad_contacto.sv
// One matrix contact: pulls the latched column low while the latched row is driven low and the contact is closed.
module keypad_contacto
    import keypad_pkg::*;
(
    input  logic [1:0] row,
    input  logic [1:0] col,
    input  logic       contact,
    input  logic [3:0] fila,
    output logic [3:0] columna
);

    always_comb begin
        columna      = COLUMNA_IDLE;
        columna[col] = ~(contact & ~fila[row]);
    end

endmodule

// File: rtl/keypad_emulador.sv
// Keypad responder: accepts one key code and plays press bounce, hold, release bounce and a quiet gap.
//
//  state | meaning
//  IDLE  | waiting for a key code, key_ready high
//  BNC_P | press bounce, contact toggles starting closed
//  HOLD  | contact solidly closed
//  BNC_R | release bounce, contact toggles starting open
//  GAP   | contact open before the next key is accepted
module keypad_emulador
    import keypad_pkg::*;
#(
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 2_000_000,
    parameter int BOUNCE_CYCLES = 100_000,
    parameter int BOUNCE_TOGGLE = 5_000,
    parameter int GAP_CYCLES    = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    keypad_emulador_if.slave   kp,
    input  logic [3:0]         fila,
    output logic [3:0]         columna
);

    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(fin_fase(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(fin_fase(GAP_CYCLES));
    localparam logic [CNT_W-1:0] BNC_END  = CNT_W'(fin_fase(BOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] TOG_END  = CNT_W'(fin_fase(BOUNCE_TOGGLE));
    localparam bit               HAY_BNC  = (BOUNCE_CYCLES > 0);

    estado_t          state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] tog, tog_nxt;
    logic             fase, fase_nxt;
    logic             contact, contact_nxt;
    logic             nokey, nokey_nxt;
    logic [1:0]       row, col;
    logic             xfer;

    assign kp.key_ready = (state == IDLE) & ~rst;
    assign kp.busy      = (state != IDLE);
    assign xfer         = kp.key_valid & kp.key_ready;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 1'b1;
        tog_nxt     = tog + 1'b1;
        fase_nxt    = fase;
        nokey_nxt   = xfer ? kp.key_in[NOKEY_BIT] : nokey;
        contact_nxt = 1'b0;
        // fase flips every BOUNCE_TOGGLE cycles, replacing a divide of the phase counter
        if (tog == TOG_END) begin
            tog_nxt  = '0;
            fase_nxt = ~fase;
        end
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (xfer) state_nxt = HAY_BNC ? BNC_P : HOLD;
            end
            BNC_P:   if (cnt == BNC_END)  state_nxt = HOLD;
            HOLD:    if (cnt == HOLD_END) state_nxt = HAY_BNC ? BNC_R : GAP;
            BNC_R:   if (cnt == BNC_END)  state_nxt = GAP;
            GAP:     if (cnt == GAP_END)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) begin
            cnt_nxt  = '0;
            tog_nxt  = '0;
            fase_nxt = 1'b0;
        end
        unique case (state_nxt)
            BNC_P:   contact_nxt = ~fase_nxt;
            HOLD:    contact_nxt = 1'b1;
            BNC_R:   contact_nxt = fase_nxt;
            default: contact_nxt = 1'b0;
        endcase
        contact_nxt = contact_nxt & ~nokey_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tog     <= '0;
            fase    <= 1'b0;
            contact <= 1'b0;
            nokey   <= 1'b0;
            row     <= '0;
            col     <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            tog     <= tog_nxt;
            fase    <= fase_nxt;
            contact <= contact_nxt;
            nokey   <= nokey_nxt;
            if (xfer) begin
                row <= kp.key_in[ROW_HI:ROW_LO];
                col <= kp.key_in[COL_HI:COL_LO];
            end
        end
    end

    keypad_contacto u_contacto (
        .row     (row),
        .col     (col),
        .contact (contact),
        .fila    (fila),
        .columna (columna)
    );

endmodule

// File: tb/tb_keypad_emulador.sv
// Bench for keypad_emulador: expected column traces are queued at each key transfer and popped cycle by cycle.
module tb_keypad_emulador;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] fila;
    logic [3:0] columna;

    keypad_emulador_if kp ();

    keypad_emulador #(
        .CNT_W         (24),
        .HOLD_CYCLES   (20),
        .BOUNCE_CYCLES (6),
        .BOUNCE_TOGGLE (2),
        .GAP_CYCLES    (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .kp      (kp),
        .fila    (fila),
        .columna (columna)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_ok  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] scan[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Contact level t cycles after leaving IDLE (6 bounce, 20 hold, 6 bounce, 10 gap).
    function automatic logic modelo_contacto(input int t, input logic nk);
        if (nk)     return 1'b0;
        if (t < 6)  return ((t / 2) % 2) == 0;
        if (t < 26) return 1'b1;
        if (t < 32) return (((t - 26) / 2) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] modelo_columna(input logic [4:0] k, input logic [3:0] f, input logic c);
        logic [3:0] r;
        r = 4'b1111;
        if (c && f[k[3:2]] == 1'b0) r[k[1:0]] = 1'b0;
        return r;
    endfunction

    function automatic logic [3:0] fila_de(input bit scanning, input logic [3:0] fs, input int i);
        return scanning ? scan[i % 4] : fs;
    endfunction

    task automatic send_key(input logic [4:0] k, input bit scanning, input logic [3:0] fs,
                            input int stop_at, input bit hold_next, output int waited, output int run_max);
        int         n;
        int         run;
        logic [3:0] got;
        logic [3:0] expv;
        n = 0;
        run = 0;
        run_max = 0;
        kp.key_in    = k;
        kp.key_valid = 1'b1;
        while (!kp.key_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        check_eq("key_ready_wait", 32'(kp.key_ready), 32'(1));
        @(posedge clk);
        for (int i = 1; i <= 42; i++)
            exp_q.push_back(modelo_columna(k, fila_de(scanning, fs, i), modelo_contacto(i - 1, k[4])));
        for (int i = 1; i <= stop_at; i++) begin
            @(negedge clk);
            kp.key_valid = hold_next;
            kp.key_in    = hold_next ? 5'b00000 : 5'b11010;
            fila         = fila_de(scanning, fs, i);
            #1;
            got  = columna;
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
            check_eq("columna", 32'(got), 32'(expv));
            check_eq("busy", 32'(kp.busy), 32'(1));
            check_eq("key_ready_busy", 32'(kp.key_ready), 32'(0));
            if (fila[k[3:2]] == 1'b0) begin
                run = (got[k[1:0]] == 1'b0) ? run + 1 : 0;
                if (run > run_max) run_max = run;
            end
        end
        if (stop_at == 42) begin
            @(negedge clk);
            #1;
            check_eq("ready_after_gap", 32'(kp.key_ready), 32'(1));
            check_eq("busy_after_gap", 32'(kp.busy), 32'(0));
            check_eq("columna_after_gap", 32'(columna), 32'(COLUMNA_IDLE));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int r;
        int run;
        int exp_run;
        rst          = 1'b1;
        fila         = 4'b1110;
        kp.key_in    = 5'b00110;
        kp.key_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_key_ready", 32'(kp.key_ready), 32'(0));
            check_eq("rst_busy", 32'(kp.busy), 32'(0));
            check_eq("rst_columna", 32'(columna), 32'(COLUMNA_IDLE));
        end
        rst          = 1'b0;
        kp.key_valid = 1'b0;
        @(negedge clk);
        #1;
        check_eq("post_rst_busy", 32'(kp.busy), 32'(0));
        check_eq("post_rst_ready", 32'(kp.key_ready), 32'(1));

        // row1/col2 with static row drive
        fila = 4'b1101;
        send_key(5'b00110, 1'b0, 4'b1101, 42, 1'b0, w, r);

        // same key under a scanning row drive; next key held valid throughout busy
        send_key(5'b00110, 1'b1, 4'b0000, 42, 1'b1, w, r);

        // held key must be taken in the very first IDLE cycle
        send_key(5'b00000, 1'b0, 4'b1110, 42, 1'b0, w, r);
        check_eq("first_idle_accept", 32'(w), 32'(0));

        // pause code: all rows low, contact must never close
        send_key(5'b10011, 1'b0, 4'b0000, 42, 1'b0, w, r);

        // reset in the middle of HOLD
        send_key(5'b01111, 1'b0, 4'b0111, 15, 1'b0, w, run);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check_eq("midrst_columna", 32'(columna), 32'(COLUMNA_IDLE));
        check_eq("midrst_busy", 32'(kp.busy), 32'(0));
        check_eq("midrst_ready", 32'(kp.key_ready), 32'(0));
        rst = 1'b0;
        exp_run = 0;
        r = 0;
        for (int t = 0; t < 15; t++) begin
            r = modelo_contacto(t, 1'b0) ? r + 1 : 0;
            if (r > exp_run) exp_run = r;
        end
        check_eq("scanner_detect", 32'(run >= 4), 32'(exp_run >= 4));
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("after_rst_ready", 32'(kp.key_ready), 32'(1));
            check_eq("after_rst_busy", 32'(kp.busy), 32'(0));
            check_eq("after_rst_columna", 32'(columna), 32'(COLUMNA_IDLE));
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
